// File: rtl/neighbor_table_ctrl_pkg.sv
// neighbor_pkg: shared state encoding and table geometry for the neighbor table controller.
package neighbor_pkg;
   localparam int NT_NUM_ENTRIES = 32;
   localparam int NT_IDX_W = $clog2(NT_NUM_ENTRIES);
   localparam int NT_CNT_W = $clog2(NT_NUM_ENTRIES + 1);
   localparam logic [15:0] MY_NODE_ID_CONST = 16'h000C;
   typedef enum logic [2:0] {ST_IDLE, ST_SEARCH, ST_WRITE, ST_SCAN, ST_CLEAR} nt_state_e;
endpackage

// File: rtl/neighbor_table_ctrl_if.sv
// neighbor_table_ctrl_if: request, scan and storage-side signals of the neighbor table controller.
interface neighbor_table_ctrl_if
   import neighbor_pkg::*;
#(
   parameter int WORD_WIDTH = 16,
   parameter int IDX_W = NT_IDX_W,
   parameter int CNT_W = NT_CNT_W
);
   logic                  wr_req;
   logic [WORD_WIDTH-1:0] wr_node_id;
   logic                  hb_reset;
   logic                  scan_req;
   logic [WORD_WIDTH-1:0] tbl_rd_node_id;
   logic                  wr_ready;
   logic [IDX_W-1:0]      tbl_idx;
   logic                  tbl_wr_en;
   logic                  tbl_clr_all;
   logic [CNT_W-1:0]      neighbor_count;
   logic                  wr_done;
   logic                  wr_dropped;
   logic                  scan_valid;
   logic                  scan_done;
   modport master (
      output wr_req, wr_node_id, hb_reset, scan_req, tbl_rd_node_id,
      input  wr_ready, tbl_idx, tbl_wr_en, tbl_clr_all, neighbor_count,
             wr_done, wr_dropped, scan_valid, scan_done
   );
   modport slave (
      input  wr_req, wr_node_id, hb_reset, scan_req, tbl_rd_node_id,
      output wr_ready, tbl_idx, tbl_wr_en, tbl_clr_all, neighbor_count,
             wr_done, wr_dropped, scan_valid, scan_done
   );
endinterface

// File: rtl/neighbor_table_ctrl.sv
// neighbor_table_ctrl: search/allocate/scan/clear sequencer that owns the neighbor count
// in front of a data+valid neighbor table storage.
module neighbor_table_ctrl
   import neighbor_pkg::*;
#(
   parameter int WORD_WIDTH = 16,
   parameter int NUM_ENTRIES = NT_NUM_ENTRIES,
   parameter logic [WORD_WIDTH-1:0] MY_NODE_ID = MY_NODE_ID_CONST
) (
   input logic clk,
   input logic nrst,
   neighbor_table_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_ENTRIES);
   nt_state_e r_state, w_state;
   logic [WORD_WIDTH-1:0] r_id_q, w_id_q;
   logic [IDX_W-1:0] r_ptr, w_ptr;
   logic [CNT_W-1:0] r_count, w_count;
   logic r_alloc_q, w_alloc_q, r_hb_pend, w_hb_pend;
   logic r_wr_done, w_wr_done, r_wr_dropped, w_wr_dropped, r_scan_done, w_scan_done;
   logic w_last, w_hit, w_empty;
   assign w_last = CNT_W'(r_ptr) == r_count - 1'b1;
   assign w_hit = bus.tbl_rd_node_id == r_id_q;
   assign w_empty = r_count == '0;
   always_comb begin
      w_state = r_state;
      w_id_q = r_id_q;
      w_ptr = r_ptr;
      w_count = r_count;
      w_alloc_q = r_alloc_q;
      w_hb_pend = r_hb_pend;
      w_wr_done = 1'b0;
      w_wr_dropped = 1'b0;
      w_scan_done = 1'b0;
      case (r_state)
         ST_IDLE:
            if (bus.hb_reset) w_state = ST_CLEAR;
            else if (bus.wr_req) begin
               w_id_q = bus.wr_node_id;
               w_ptr = '0;
               if (bus.wr_node_id == MY_NODE_ID) begin
                  w_wr_done = 1'b1;
                  w_wr_dropped = 1'b1;
               end else begin
                  w_state = w_empty ? ST_WRITE : ST_SEARCH;
                  w_alloc_q = w_empty;
               end
            end else if (bus.scan_req) begin
               w_state = ST_SCAN;
               w_ptr = '0;
            end
         ST_SEARCH:
            if (bus.hb_reset) begin
               w_state = ST_CLEAR;
               w_wr_done = 1'b1;
               w_wr_dropped = 1'b1;
            end else if (w_hit) begin
               w_state = ST_WRITE;
               w_alloc_q = 1'b0;
            end else if (w_last && r_count == FULL) begin
               w_state = ST_IDLE;
               w_wr_done = 1'b1;
               w_wr_dropped = 1'b1;
            end else if (w_last) begin
               w_state = ST_WRITE;
               w_ptr = r_count[IDX_W-1:0];
               w_alloc_q = 1'b1;
            end else w_ptr = r_ptr + 1'b1;
         ST_WRITE: begin
            w_wr_done = 1'b1;
            w_count = (r_alloc_q && r_count != FULL) ? r_count + 1'b1 : r_count;
            w_hb_pend = r_hb_pend | bus.hb_reset;
            w_state = (r_hb_pend || bus.hb_reset) ? ST_CLEAR : ST_IDLE;
         end
         ST_SCAN:
            if (bus.hb_reset) w_state = ST_CLEAR;
            else if (w_empty || w_last) begin
               w_state = ST_IDLE;
               w_scan_done = 1'b1;
            end else w_ptr = r_ptr + 1'b1;
         ST_CLEAR: begin
            w_state = ST_IDLE;
            w_count = '0;
            w_hb_pend = 1'b0;
         end
         default: w_state = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
         r_id_q <= '0;
         r_ptr <= '0;
         r_count <= '0;
         r_alloc_q <= 1'b0;
         r_hb_pend <= 1'b0;
         r_wr_done <= 1'b0;
         r_wr_dropped <= 1'b0;
         r_scan_done <= 1'b0;
      end else begin
         r_state <= w_state;
         r_id_q <= w_id_q;
         r_ptr <= w_ptr;
         r_count <= w_count;
         r_alloc_q <= w_alloc_q;
         r_hb_pend <= w_hb_pend;
         r_wr_done <= w_wr_done;
         r_wr_dropped <= w_wr_dropped;
         r_scan_done <= w_scan_done;
      end
   end
   assign bus.wr_ready = r_state == ST_IDLE;
   assign bus.tbl_idx = r_ptr;
   assign bus.tbl_wr_en = r_state == ST_WRITE;
   assign bus.tbl_clr_all = r_state == ST_CLEAR;
   assign bus.scan_valid = r_state == ST_SCAN && !w_empty;
   assign bus.neighbor_count = r_count;
   assign bus.wr_done = r_wr_done;
   assign bus.wr_dropped = r_wr_dropped;
   assign bus.scan_done = r_scan_done;
endmodule

// File: tb/tb_neighbor_table_ctrl.sv
// tb_neighbor_table_ctrl: directed bench with a behavioural table storage and hand-computed latencies.
module tb_neighbor_table_ctrl;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [15:0] cur_id = '0;
   logic [15:0] mem [32];
   int scan_seen [$];
   always #5 clk = ~clk;
   neighbor_table_ctrl_if #(.WORD_WIDTH(16), .IDX_W(5), .CNT_W(6)) bus ();
   neighbor_table_ctrl #(.WORD_WIDTH(16), .NUM_ENTRIES(32), .MY_NODE_ID(16'h000C)) dut (
      .clk(clk), .nrst(nrst), .bus(bus));
   assign bus.tbl_rd_node_id = mem[bus.tbl_idx];
   always @(posedge clk) if (bus.tbl_wr_en) mem[bus.tbl_idx] <= cur_id;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send_write(input logic [15:0] id, output int lat, output int wen_cnt,
                             output int wen_idx, output logic dropped);
      lat = -1; wen_cnt = 0; wen_idx = -1; dropped = 1'bx;
      cur_id = id;
      bus.wr_node_id = id;
      bus.wr_req = 1'b1;
      for (int t = 1; t <= 100; t++) begin
         tick();
         bus.wr_req = 1'b0;
         if (bus.tbl_wr_en) begin
            wen_cnt++;
            wen_idx = int'(bus.tbl_idx);
         end
         if (bus.wr_done) begin
            lat = t;
            dropped = bus.wr_dropped;
            break;
         end
      end
   endtask
   task automatic send_scan(output int lat);
      lat = -1;
      scan_seen.delete();
      bus.scan_req = 1'b1;
      for (int t = 1; t <= 100; t++) begin
         tick();
         bus.scan_req = 1'b0;
         if (bus.scan_valid) scan_seen.push_back(int'(bus.tbl_idx));
         if (bus.scan_done) begin
            lat = t;
            break;
         end
      end
   endtask
   task automatic test_reset();
      nrst = 1'b0;
      repeat (3) tick();
      nrst = 1'b1;
      tick();
      checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.wr_ready); end
      checks++; if (bus.tbl_idx !== 5'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.tbl_idx); end
      checks++; if (bus.neighbor_count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.neighbor_count); end
      checks++; if ({bus.tbl_wr_en, bus.tbl_clr_all, bus.wr_done, bus.wr_dropped, bus.scan_valid, bus.scan_done} !== 6'b0)
         begin failures++; $display("FAIL reset_strobes got=%b exp=000000",
            {bus.tbl_wr_en, bus.tbl_clr_all, bus.wr_done, bus.wr_dropped, bus.scan_valid, bus.scan_done}); end
   endtask
   task automatic test_alloc();
      int lat, wc, wi; logic dr;
      for (int i = 0; i < 3; i++) begin
         send_write(16'(i + 1), lat, wc, wi, dr);
         checks++; if (lat !== i + 2) begin failures++; $display("FAIL alloc%0d_latency got=%0d exp=%0d", i, lat, i + 2); end
         checks++; if (wc !== 1 || wi !== i) begin failures++; $display("FAIL alloc%0d_write got=%0d@%0d exp=1@%0d", i, wc, wi, i); end
         checks++; if (dr !== 1'b0) begin failures++; $display("FAIL alloc%0d_dropped got=%b exp=0", i, dr); end
         checks++; if (bus.neighbor_count !== 6'(i + 1)) begin failures++; $display("FAIL alloc%0d_count got=%0d exp=%0d", i, bus.neighbor_count, i + 1); end
      end
   endtask
   task automatic test_hit();
      int lat, wc, wi; logic dr;
      send_write(16'h0002, lat, wc, wi, dr);
      checks++; if (lat !== 4) begin failures++; $display("FAIL hit_latency got=%0d exp=4", lat); end
      checks++; if (wc !== 1 || wi !== 1) begin failures++; $display("FAIL hit_write got=%0d@%0d exp=1@1", wc, wi); end
      checks++; if (dr !== 1'b0) begin failures++; $display("FAIL hit_dropped got=%b exp=0", dr); end
      checks++; if (bus.neighbor_count !== 6'd3) begin failures++; $display("FAIL hit_count got=%0d exp=3", bus.neighbor_count); end
   endtask
   task automatic test_self_id();
      int lat, wc, wi; logic dr;
      send_write(16'h000C, lat, wc, wi, dr);
      checks++; if (lat !== 1) begin failures++; $display("FAIL self_latency got=%0d exp=1", lat); end
      checks++; if (wc !== 0) begin failures++; $display("FAIL self_write got=%0d exp=0", wc); end
      checks++; if (dr !== 1'b1) begin failures++; $display("FAIL self_dropped got=%b exp=1", dr); end
      checks++; if (bus.neighbor_count !== 6'd3) begin failures++; $display("FAIL self_count got=%0d exp=3", bus.neighbor_count); end
   endtask
   task automatic test_scan();
      int lat;
      send_scan(lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL scan3_done_latency got=%0d exp=4", lat); end
      checks++; if (scan_seen.size() !== 3) begin failures++; $display("FAIL scan3_valid_cycles got=%0d exp=3", scan_seen.size()); end
      for (int i = 0; i < scan_seen.size() && i < 3; i++) begin
         checks++; if (scan_seen[i] !== i) begin failures++; $display("FAIL scan3_idx%0d got=%0d exp=%0d", i, scan_seen[i], i); end
      end
      checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL scan3_ready got=%b exp=1", bus.wr_ready); end
   endtask
   task automatic test_hb_search();
      int wc = 0;
      cur_id = 16'h0055;
      bus.wr_node_id = 16'h0055;
      bus.wr_req = 1'b1;
      tick();
      bus.wr_req = 1'b0;
      checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL hbs_in_search got=%b exp=0", bus.wr_ready); end
      bus.hb_reset = 1'b1;
      tick();
      bus.hb_reset = 1'b0;
      if (bus.tbl_wr_en) wc++;
      checks++; if ({bus.wr_done, bus.wr_dropped, bus.tbl_clr_all} !== 3'b111)
         begin failures++; $display("FAIL hbs_abort got=%b exp=111", {bus.wr_done, bus.wr_dropped, bus.tbl_clr_all}); end
      tick();
      if (bus.tbl_wr_en) wc++;
      checks++; if (bus.neighbor_count !== 6'd0 || bus.wr_ready !== 1'b1)
         begin failures++; $display("FAIL hbs_after got=%0d/%b exp=0/1", bus.neighbor_count, bus.wr_ready); end
      checks++; if (wc !== 0) begin failures++; $display("FAIL hbs_no_write got=%0d exp=0", wc); end
   endtask
   task automatic test_hb_idle_scan_empty();
      int lat, wc, wi; logic dr;
      send_write(16'h0077, lat, wc, wi, dr);
      checks++; if (bus.neighbor_count !== 6'd1) begin failures++; $display("FAIL hbi_prefill got=%0d exp=1", bus.neighbor_count); end
      bus.hb_reset = 1'b1;
      tick();
      bus.hb_reset = 1'b0;
      checks++; if (bus.tbl_clr_all !== 1'b1) begin failures++; $display("FAIL hbi_clear got=%b exp=1", bus.tbl_clr_all); end
      tick();
      checks++; if (bus.neighbor_count !== 6'd0 || bus.wr_ready !== 1'b1)
         begin failures++; $display("FAIL hbi_after got=%0d/%b exp=0/1", bus.neighbor_count, bus.wr_ready); end
      send_scan(lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL scan0_done_latency got=%0d exp=2", lat); end
      checks++; if (scan_seen.size() !== 0) begin failures++; $display("FAIL scan0_valid_cycles got=%0d exp=0", scan_seen.size()); end
   endtask
   task automatic test_hb_write();
      int lat, wc, wi; logic dr;
      send_write(16'h0077, lat, wc, wi, dr);
      cur_id = 16'h0088;
      bus.wr_node_id = 16'h0088;
      bus.wr_req = 1'b1;
      tick();
      bus.wr_req = 1'b0;
      tick();
      checks++; if (bus.tbl_wr_en !== 1'b1 || bus.tbl_idx !== 5'd1)
         begin failures++; $display("FAIL hbw_write got=%b@%0d exp=1@1", bus.tbl_wr_en, bus.tbl_idx); end
      bus.hb_reset = 1'b1;
      tick();
      bus.hb_reset = 1'b0;
      checks++; if ({bus.wr_done, bus.wr_dropped, bus.tbl_clr_all} !== 3'b101)
         begin failures++; $display("FAIL hbw_done_clear got=%b exp=101", {bus.wr_done, bus.wr_dropped, bus.tbl_clr_all}); end
      checks++; if (mem[1] !== 16'h0088) begin failures++; $display("FAIL hbw_landed got=%h exp=0088", mem[1]); end
      tick();
      checks++; if (bus.neighbor_count !== 6'd0 || bus.wr_ready !== 1'b1 || bus.tbl_clr_all !== 1'b0)
         begin failures++; $display("FAIL hbw_after got=%0d/%b/%b exp=0/1/0", bus.neighbor_count, bus.wr_ready, bus.tbl_clr_all); end
   endtask
   task automatic test_full();
      int lat, wc, wi; logic dr;
      int bad = 0;
      for (int i = 0; i < 32; i++) begin
         send_write(16'h0100 + 16'(i), lat, wc, wi, dr);
         if (lat != i + 2 || wi != i) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL fill_timing got=%0d_bad exp=0_bad", bad); end
      checks++; if (bus.neighbor_count !== 6'd32) begin failures++; $display("FAIL fill_count got=%0d exp=32", bus.neighbor_count); end
      send_write(16'h00FF, lat, wc, wi, dr);
      checks++; if (lat !== 33) begin failures++; $display("FAIL full_miss_latency got=%0d exp=33", lat); end
      checks++; if (dr !== 1'b1 || wc !== 0) begin failures++; $display("FAIL full_miss_drop got=%b/%0d exp=1/0", dr, wc); end
      checks++; if (bus.neighbor_count !== 6'd32 || bus.wr_ready !== 1'b1)
         begin failures++; $display("FAIL full_miss_after got=%0d/%b exp=32/1", bus.neighbor_count, bus.wr_ready); end
      send_write(16'h011F, lat, wc, wi, dr);
      checks++; if (lat !== 34 || wi !== 31 || dr !== 1'b0)
         begin failures++; $display("FAIL full_hit_last got=%0d/%0d/%b exp=34/31/0", lat, wi, dr); end
      checks++; if (bus.neighbor_count !== 6'd32) begin failures++; $display("FAIL full_hit_count got=%0d exp=32", bus.neighbor_count); end
   endtask
   initial begin
      bus.wr_req = 1'b0;
      bus.wr_node_id = '0;
      bus.hb_reset = 1'b0;
      bus.scan_req = 1'b0;
      test_reset();
      test_alloc();
      test_hit();
      test_self_id();
      test_scan();
      test_hb_search();
      test_hb_idle_scan_empty();
      test_hb_write();
      test_full();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/neighbor_table_ctrl.md
# neighbor_table_ctrl

Sequencer in front of the 32-entry neighbor table storage. It turns single-cycle write requests from QTableUpdate into a search-then-update or search-then-allocate sequence, and drops requests that carry the node's own ID or arrive when the table is full. It also clears the table on heartbeat reset and streams valid entries out one per cycle so the cluster head can build timeslots. It owns the neighbor count; the storage instance holds only data and valid bits.

## Interface
- `WORD_WIDTH`, 16, width of node ID and table words
- `NUM_ENTRIES`, 32, table depth; `IDX_W = $clog2(NUM_ENTRIES)`, `CNT_W = $clog2(NUM_ENTRIES+1)`
- `MY_NODE_ID`, 16'h000C, this node's ID
- `clk` in 1: single clock, all logic on rising edge
- `nrst` in 1: synchronous, active-low reset
- `wr_req` in 1: write request, accepted only when `wr_ready`
- `wr_node_id` in WORD_WIDTH: ID of the neighbor to record
- `hb_reset` in 1: heartbeat reset, one-cycle pulse
- `scan_req` in 1: start an entry scan, accepted only when `wr_ready`
- `tbl_rd_node_id` in WORD_WIDTH: combinational ID read from storage at `tbl_idx`
- `wr_ready` out 1: controller is in IDLE
- `tbl_idx` out IDX_W: storage address
- `tbl_wr_en` out 1: storage write strobe; storage sets the valid bit
- `tbl_clr_all` out 1: storage clears all valid bits
- `neighbor_count` out CNT_W: number of valid entries, always contiguous from 0
- `wr_done` out 1: one-cycle pulse, write request finished
- `wr_dropped` out 1: qualifies `wr_done`; request was not stored
- `scan_valid` out 1: `tbl_idx` holds a valid entry during SCAN
- `scan_done` out 1: one-cycle pulse, scan finished

## Operation
- States: IDLE, SEARCH, WRITE, SCAN, CLEAR. Latched registers: `id_q`, `ptr` (IDX_W), `alloc_q`, `hb_pend`.
- IDLE priority: `hb_reset`, then `wr_req`, then `scan_req`.
- `wr_req` with `wr_node_id == MY_NODE_ID`: stay in IDLE; `wr_done` and `wr_dropped` pulse next cycle.
- Other `wr_req` when count is 0: go to WRITE with `ptr=0` and `alloc_q=1`.
- Other `wr_req` when count is nonzero: go to SEARCH with `ptr=0`.
- SEARCH drives `tbl_idx=ptr` and evaluates in this order:
  - Hit (`tbl_rd_node_id == id_q`): go to WRITE with `alloc_q=0`, keeping `ptr`.
  - Otherwise, if `ptr == count-1` and count is `NUM_ENTRIES`: drop and return to IDLE.
  - Otherwise, if `ptr == count-1`: go to WRITE with `ptr=count` and `alloc_q=1`.
  - Otherwise: increment `ptr` and stay in SEARCH.
- WRITE: `tbl_wr_en=1` and `tbl_idx=ptr` for one cycle; if `alloc_q`, increment count; return to IDLE.
- SCAN:
  - Count 0: `scan_done` without any `scan_valid`; return to IDLE.
  - Otherwise: `scan_valid=1`, `tbl_idx=ptr` from 0 to count-1, one entry per cycle; after the last entry, return to IDLE.
- CLEAR: `tbl_clr_all=1` for one cycle, count set to 0, `hb_pend` cleared; return to IDLE.
- `hb_reset` in SEARCH: abort to CLEAR, no write; `wr_done` and `wr_dropped` pulse next cycle.
- `hb_reset` in SCAN: abort to CLEAR; `scan_done` is not pulsed.
- `hb_reset` in WRITE: set `hb_pend`; the write completes, then CLEAR instead of IDLE.
- `hb_reset` in CLEAR: ignored.
- `wr_req` or `scan_req` while not ready: ignored; the requester holds the request.

## Timing
- Reset values: state IDLE, count 0, `ptr` 0, `hb_pend` 0.
- Reset output values: `wr_ready=1`, `tbl_idx=0`; `tbl_wr_en`, `tbl_clr_all`, `wr_done`, `wr_dropped`, `scan_valid` and `scan_done` all 0.
- `tbl_*`, `scan_valid` and `wr_ready` decode from registered state (Moore). `wr_done`, `wr_dropped` and `scan_done` are registered pulses.
- New ID accepted at cycle T with count N>0:
  - SEARCH during T+1..T+N, WRITE at T+N+1.
  - `wr_done` and count=N+1 at T+N+2.
- Hit at index k: WRITE at T+k+2, `wr_done` at T+k+3, count unchanged.
- Count 0: WRITE at T+1, `wr_done` at T+2.
- Full and miss: `wr_done` and `wr_dropped` at T+N+1, IDLE at T+N+1.
- Self-ID request: `wr_done` and `wr_dropped` at T+1.
- Scan accepted at T: `scan_valid` during T+1..T+N; `scan_done` at T+N+1; IDLE at T+N+1.
- `hb_reset` at T in IDLE: CLEAR at T+1, count 0 and IDLE at T+2.
- Count saturates at `NUM_ENTRIES` and never wraps. `ptr` compares are against count-1 at CNT_W width.

## Structure
- Package `neighbor_pkg` holds:
  - the state enum `nt_state_e`;
  - `NT_NUM_ENTRIES`, `NT_IDX_W`, `NT_CNT_W`;
  - `MY_NODE_ID_CONST`.
- No sub-module. Storage is a separate instance driven by the `tbl_*` ports.

## Test plan
- Reset, then IDs 0x0001, 0x0002, 0x0003 one after another → writes at idx 0/1/2; `wr_done` latencies 2, 3 and 4 cycles; count=3.
- With count=3, ID 0x0002 again → hit, write at idx 1, `wr_done` at T+4, count stays 3.
- ID 0x000C → `wr_done` and `wr_dropped` at T+1, no `tbl_wr_en`, count unchanged.
- Fill 32 distinct IDs, then ID 0x00FF → 32 search cycles, `wr_done` and `wr_dropped` at T+33, count=32.
- Scan with count=3 → `scan_valid` for 3 cycles at idx 0,1,2, then `scan_done`; with count=0 → `scan_done` at T+2 and no `scan_valid`.
- `hb_reset` during SEARCH → abort with `wr_dropped`. During WRITE → write lands, then `tbl_clr_all`. In both cases count=0 and `wr_ready=1` afterwards.
